// File: rtl/mdu_unit_pkg.sv
// mdu_unit_pkg: shared definitions for the multiply/divide unit.
//   - MDU op encodings (mdu_op_e) and their width MDU_OP_W
//   - mfSel encodings MDU_SEL_LO / MDU_SEL_HI
//   - op classification helpers used by mdu_unit
// Optional feature macro: MDU_MADD_EN.
//   When it is defined, the multiply-accumulate ops (MADD, MADDU, MSUB, MSUBU)
//   are accepted. When it is undefined, those ops are treated as NONE.
package mdu_unit_pkg;

  localparam int MDU_OP_W = 4;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MADD  = 4'd7,
    MDU_MADDU = 4'd8,
    MDU_MSUB  = 4'd9,
    MDU_MSUBU = 4'd10
  } mdu_op_e;

  localparam logic MDU_SEL_LO = 1'b0;
  localparam logic MDU_SEL_HI = 1'b1;

  function automatic logic is_div(logic [MDU_OP_W-1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // Ops that occupy the unit for a multi-cycle operation.
  function automatic logic is_md(logic [MDU_OP_W-1:0] op);
    logic r;
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: purely combinational arithmetic core of the multiply/divide unit.
// Ports:
//   op_i       : MDU op (mdu_op_e encoding)
//   a_i, b_i   : rs / rt operands
//   hilo_i     : current {HI,LO}, used as the accumulate base
//   res_o      : 64-bit result {HI,LO}
//   div_zero_o : div/divu with b_i == 0 (commit must leave HI/LO untouched)
module mdu_calc
  import mdu_unit_pkg::*;
(
  input  logic [MDU_OP_W-1:0] op_i,
  input  logic [31:0]         a_i,
  input  logic [31:0]         b_i,
  input  logic [63:0]         hilo_i,
  output logic [63:0]         res_o,
  output logic                div_zero_o
);

  logic signed [63:0] a_sext;
  logic signed [63:0] b_sext;
  logic signed [63:0] s_prod;
  logic        [63:0] u_prod;

  logic        [31:0] a_mag;
  logic        [31:0] b_mag;
  logic        [31:0] mq;
  logic        [31:0] mr;
  logic        [31:0] uq;
  logic        [31:0] ur;
  logic        [31:0] sq;
  logic        [31:0] sr;

  assign a_sext = $signed({{32{a_i[31]}}, a_i});
  assign b_sext = $signed({{32{b_i[31]}}, b_i});
  assign s_prod = a_sext * b_sext;
  assign u_prod = {32'd0, a_i} * {32'd0, b_i};

  // Signed division runs on magnitudes and re-applies signs. The magnitude of
  // 0x80000000 is representable as unsigned, so the 0x80000000 / -1 overflow
  // case falls out naturally as quotient 0x80000000, remainder 0.
  assign a_mag = a_i[31] ? (32'd0 - a_i) : a_i;
  assign b_mag = b_i[31] ? (32'd0 - b_i) : b_i;
  assign mq    = (b_i == 32'd0) ? 32'd0 : (a_mag / b_mag);
  assign mr    = (b_i == 32'd0) ? 32'd0 : (a_mag % b_mag);
  assign sq    = (a_i[31] ^ b_i[31]) ? (32'd0 - mq) : mq;
  assign sr    = a_i[31] ? (32'd0 - mr) : mr;

  assign uq    = (b_i == 32'd0) ? 32'd0 : (a_i / b_i);
  assign ur    = (b_i == 32'd0) ? 32'd0 : (a_i % b_i);

  assign div_zero_o = is_div(op_i) && (b_i == 32'd0);

  always_comb begin
    res_o = hilo_i;
    case (op_i)
      MDU_MULT:  res_o = $unsigned(s_prod);
      MDU_MULTU: res_o = u_prod;
      MDU_DIV:   res_o = {sr, sq};
      MDU_DIVU:  res_o = {ur, uq};
      MDU_MADD:  res_o = hilo_i + $unsigned(s_prod);
      MDU_MADDU: res_o = hilo_i + u_prod;
      MDU_MSUB:  res_o = hilo_i - $unsigned(s_prod);
      MDU_MSUBU: res_o = hilo_i - u_prod;
      default:   res_o = hilo_i;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: E-stage multiply/divide unit owning the HI/LO registers.
// Optional feature macro: MDU_MADD_EN (multiply-accumulate ops 7..10).
// Parameters:
//   MULT_CYCLES : busy cycles for mult/multu/madd family (1..15)
//   DIV_CYCLES  : busy cycles for div/divu (1..15)
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   MDUOp  : E-stage MDU op (mdu_op_e encoding, 11..15 = NONE)
//   flush  : E-stage instruction killed; blocks start and mt writes
//   A, B   : forwarded rs / rt operands
//   mfSel  : 0 reads LO, 1 reads HI onto mfData
//   start  : op accepted this cycle (combinational)
//   busy   : operation in flight (registered)
//   HI, LO : architectural HI/LO
//   mfData : mfSel ? HI : LO (combinational)
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [MDU_OP_W-1:0] MDUOp,
  input  logic                flush,
  input  logic [31:0]         A,
  input  logic [31:0]         B,
  input  logic                mfSel,
  output logic                start,
  output logic                busy,
  output logic [31:0]         HI,
  output logic [31:0]         LO,
  output logic [31:0]         mfData
);

  logic        busy_q;
  logic [3:0]  cnt_q;
  logic [63:0] pend_q;
  logic        pend_dz_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [63:0] calc_res;
  logic        calc_dz;

  mdu_calc u_calc (
    .op_i       (MDUOp),
    .a_i        (A),
    .b_i        (B),
    .hilo_i     ({hi_q, lo_q}),
    .res_o      (calc_res),
    .div_zero_o (calc_dz)
  );

  assign start  = is_md(MDUOp) & ~flush & ~busy_q & reset;
  assign busy   = busy_q;
  assign HI     = hi_q;
  assign LO     = lo_q;
  assign mfData = (mfSel == MDU_SEL_HI) ? hi_q : lo_q;

  // Result is computed at accept and held in pend_q; HI/LO only change on the
  // final busy edge, so mfData never exposes an uncommitted value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q    <= 1'b0;
      cnt_q     <= 4'd0;
      pend_q    <= 64'd0;
      pend_dz_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else if (start) begin
      pend_q    <= calc_res;
      pend_dz_q <= calc_dz;
      cnt_q     <= is_div(MDUOp) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      busy_q    <= 1'b1;
    end else if (busy_q) begin
      cnt_q <= cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_q <= 1'b0;
        if (!pend_dz_q) begin
          hi_q <= pend_q[63:32];
          lo_q <= pend_q[31:0];
        end
      end
    end else if (!flush) begin
      if (MDUOp == MDU_MTHI) hi_q <= A;
      if (MDUOp == MDU_MTLO) lo_q <= A;
    end
  end

endmodule
